// File: rtl/dual_retire_tracer.sv
// Merges the two write-back retirement lanes into one program-ordered trace
// stream, buffered by a FIFO with sticky overflow and per-retirement sequence numbers.
module dual_retire_tracer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16
) (
  input  logic                      clk,
  input  logic                      rstn_i,
  input  logic                      clr_i,
  input  logic                      a_valid_i,
  input  logic [31:0]               a_pc_i,
  input  logic [31:0]               a_instr_i,
  input  logic                      a_reg_wrt_i,
  input  logic [4:0]                a_reg_addr_i,
  input  logic [31:0]               a_reg_data_i,
  input  logic                      a_mem_wrt_i,
  input  logic [31:0]               a_mem_addr_i,
  input  logic [31:0]               a_mem_data_i,
  input  logic                      b_valid_i,
  input  logic [31:0]               b_pc_i,
  input  logic [31:0]               b_instr_i,
  input  logic                      b_reg_wrt_i,
  input  logic [4:0]                b_reg_addr_i,
  input  logic [31:0]               b_reg_data_i,
  input  logic                      b_mem_wrt_i,
  input  logic [31:0]               b_mem_addr_i,
  input  logic [31:0]               b_mem_data_i,
  input  logic                      order_change_w_i,
  output logic                      trc_valid_o,
  input  logic                      trc_ready_i,
  output logic [31:0]               trc_pc_o,
  output logic [31:0]               trc_instr_o,
  output logic [4:0]                trc_reg_addr_o,
  output logic [31:0]               trc_reg_data_o,
  output logic                      trc_reg_wrt_o,
  output logic                      trc_mem_wrt_o,
  output logic [31:0]               trc_mem_addr_o,
  output logic [31:0]               trc_mem_data_o,
  output logic [SEQ_W-1:0]          trc_seq_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             reg_wrt;
    logic [4:0]       reg_addr;
    logic [31:0]      reg_data;
    logic             mem_wrt;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
  } entry_t;

  // Drop writes to x0 and zero the payload of fields that carry no effect.
  function automatic entry_t norm(input entry_t raw, input logic [SEQ_W-1:0] seq);
    entry_t e;
    e          = raw;
    e.seq      = seq;
    e.reg_wrt  = raw.reg_wrt & (raw.reg_addr != 5'd0);
    e.reg_addr = e.reg_wrt ? raw.reg_addr : 5'd0;
    e.reg_data = e.reg_wrt ? raw.reg_data : 32'd0;
    e.mem_addr = raw.mem_wrt ? raw.mem_addr : 32'd0;
    e.mem_data = raw.mem_wrt ? raw.mem_data : 32'd0;
    return e;
  endfunction

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    level_q, level_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  entry_t        a_e, b_e, old_e, yng_e, first_e, second_e, head;
  logic          old_v, yng_v, pop;
  logic [1:0]    need, n_push;
  logic [PW-1:0] free;
  logic [AW-1:0] widx0, widx1;

  // Lane ordering, free-space arbitration and next-state computation.
  always_comb begin
    a_e          = '0;
    a_e.pc       = a_pc_i;
    a_e.instr    = a_instr_i;
    a_e.reg_wrt  = a_valid_i & a_reg_wrt_i;
    a_e.reg_addr = a_reg_addr_i;
    a_e.reg_data = a_reg_data_i;
    a_e.mem_wrt  = a_mem_wrt_i;
    a_e.mem_addr = a_mem_addr_i;
    a_e.mem_data = a_mem_data_i;
    b_e          = '0;
    b_e.pc       = b_pc_i;
    b_e.instr    = b_instr_i;
    b_e.reg_wrt  = b_valid_i & b_reg_wrt_i;
    b_e.reg_addr = b_reg_addr_i;
    b_e.reg_data = b_reg_data_i;
    b_e.mem_wrt  = b_mem_wrt_i;
    b_e.mem_addr = b_mem_addr_i;
    b_e.mem_data = b_mem_data_i;

    old_v = order_change_w_i ? b_valid_i : a_valid_i;
    yng_v = order_change_w_i ? a_valid_i : b_valid_i;
    old_e = order_change_w_i ? b_e : a_e;
    yng_e = order_change_w_i ? a_e : b_e;
    need  = 2'(old_v) + 2'(yng_v);
    free  = PW'(DEPTH) - level_q;

    if (free == '0)                       n_push = 2'd0;
    else if (free == PW'(1) && need == 2'd2) n_push = 2'd1;
    else                                  n_push = need;

    first_e  = old_v ? norm(old_e, seq_q) : norm(yng_e, seq_q);
    second_e = norm(yng_e, seq_q + SEQ_W'(1));
    widx0    = wptr_q[AW-1:0];
    widx1    = wptr_q[AW-1:0] + AW'(1);

    pop     = valid_q & trc_ready_i;
    wptr_d  = wptr_q + PW'(n_push);
    rptr_d  = rptr_q + PW'(pop);
    level_d = level_q + PW'(n_push) - PW'(pop);
    seq_d   = seq_q + SEQ_W'(need);
    ovf_d   = ovf_q | (need > n_push);
    valid_d = (level_d != '0);
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (n_push != 2'd0) mem_q[widx0] <= first_e;
      if (n_push == 2'd2) mem_q[widx1] <= second_e;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign head           = mem_q[rptr_q[AW-1:0]];
  assign trc_valid_o    = valid_q;
  assign trc_pc_o       = head.pc;
  assign trc_instr_o    = head.instr;
  assign trc_reg_addr_o = head.reg_addr;
  assign trc_reg_data_o = head.reg_data;
  assign trc_reg_wrt_o  = head.reg_wrt;
  assign trc_mem_wrt_o  = head.mem_wrt;
  assign trc_mem_addr_o = head.mem_addr;
  assign trc_mem_data_o = head.mem_data;
  assign trc_seq_o      = head.seq;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_dual_retire_tracer.sv
// Directed bench for dual_retire_tracer: ordering, x0 filter, backpressure, overflow, clear, reset.
module tb_dual_retire_tracer;

  logic        clk = 1'b0;
  logic        rstn_i, clr_i;
  logic        a_valid_i, a_reg_wrt_i, a_mem_wrt_i;
  logic [31:0] a_pc_i, a_instr_i, a_reg_data_i, a_mem_addr_i, a_mem_data_i;
  logic [4:0]  a_reg_addr_i;
  logic        b_valid_i, b_reg_wrt_i, b_mem_wrt_i;
  logic [31:0] b_pc_i, b_instr_i, b_reg_data_i, b_mem_addr_i, b_mem_data_i;
  logic [4:0]  b_reg_addr_i;
  logic        order_change_w_i, trc_ready_i;
  logic        trc_valid_o, trc_reg_wrt_o, trc_mem_wrt_o, overflow_o;
  logic [31:0] trc_pc_o, trc_instr_o, trc_reg_data_o, trc_mem_addr_o, trc_mem_data_o;
  logic [4:0]  trc_reg_addr_o;
  logic [15:0] trc_seq_o;
  logic [3:0]  level_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dual_retire_tracer #(.DEPTH(8), .SEQ_W(16)) dut (
    .clk(clk), .rstn_i(rstn_i), .clr_i(clr_i),
    .a_valid_i(a_valid_i), .a_pc_i(a_pc_i), .a_instr_i(a_instr_i),
    .a_reg_wrt_i(a_reg_wrt_i), .a_reg_addr_i(a_reg_addr_i), .a_reg_data_i(a_reg_data_i),
    .a_mem_wrt_i(a_mem_wrt_i), .a_mem_addr_i(a_mem_addr_i), .a_mem_data_i(a_mem_data_i),
    .b_valid_i(b_valid_i), .b_pc_i(b_pc_i), .b_instr_i(b_instr_i),
    .b_reg_wrt_i(b_reg_wrt_i), .b_reg_addr_i(b_reg_addr_i), .b_reg_data_i(b_reg_data_i),
    .b_mem_wrt_i(b_mem_wrt_i), .b_mem_addr_i(b_mem_addr_i), .b_mem_data_i(b_mem_data_i),
    .order_change_w_i(order_change_w_i),
    .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i),
    .trc_pc_o(trc_pc_o), .trc_instr_o(trc_instr_o), .trc_reg_addr_o(trc_reg_addr_o),
    .trc_reg_data_o(trc_reg_data_o), .trc_reg_wrt_o(trc_reg_wrt_o),
    .trc_mem_wrt_o(trc_mem_wrt_o), .trc_mem_addr_o(trc_mem_addr_o),
    .trc_mem_data_o(trc_mem_data_o), .trc_seq_o(trc_seq_o),
    .level_o(level_o), .overflow_o(overflow_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_lanes();
    a_valid_i = 0; a_pc_i = 0; a_instr_i = 0; a_reg_wrt_i = 0; a_reg_addr_i = 0;
    a_reg_data_i = 0; a_mem_wrt_i = 0; a_mem_addr_i = 0; a_mem_data_i = 0;
    b_valid_i = 0; b_pc_i = 0; b_instr_i = 0; b_reg_wrt_i = 0; b_reg_addr_i = 0;
    b_reg_data_i = 0; b_mem_wrt_i = 0; b_mem_addr_i = 0; b_mem_data_i = 0;
    order_change_w_i = 0;
  endtask

  // One retirement cycle; lanes are cleared again afterwards.
  task automatic retire(input logic av, input logic [31:0] apc,
                        input logic bv, input logic [31:0] bpc, input logic oc);
    a_valid_i = av; a_pc_i = apc; a_instr_i = apc ^ 32'hA5A5_0000;
    b_valid_i = bv; b_pc_i = bpc; b_instr_i = bpc ^ 32'hA5A5_0000;
    order_change_w_i = oc;
    step();
    idle_lanes();
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [15:0] seq);
    chk({tag, "_valid"}, 64'(trc_valid_o), 64'd1);
    chk({tag, "_pc"}, 64'(trc_pc_o), 64'(pc));
    chk({tag, "_seq"}, 64'(trc_seq_o), 64'(seq));
  endtask

  logic [31:0] hold_pc, hold_instr;
  logic [15:0] hold_seq;

  initial begin
    rstn_i = 0; clr_i = 0; trc_ready_i = 0;
    idle_lanes();
    #12;
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_valid", 64'(trc_valid_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_pc", 64'(trc_pc_o), 64'd0);
    chk("rst_seq", 64'(trc_seq_o), 64'd0);
    @(negedge clk);
    rstn_i = 1;
    step();

    // Order swap
    trc_ready_i = 1;
    retire(1, 32'h100, 1, 32'h104, 0);
    expect_head("ord0", 32'h100, 16'd0);
    chk("ord0_level", 64'(level_o), 64'd2);
    step();
    expect_head("ord1", 32'h104, 16'd1);
    retire(1, 32'h10C, 1, 32'h108, 1);
    expect_head("ord2", 32'h108, 16'd2);
    step();
    expect_head("ord3", 32'h10C, 16'd3);
    step();
    chk("ord_empty", 64'(trc_valid_o), 64'd0);

    // x0 filter and field zeroing
    trc_ready_i = 0;
    a_valid_i = 1; a_pc_i = 32'h180; a_reg_wrt_i = 1; a_reg_addr_i = 0; a_reg_data_i = 32'hDEAD;
    a_mem_wrt_i = 0; a_mem_addr_i = 32'h1234; a_mem_data_i = 32'h5678;
    b_valid_i = 1; b_pc_i = 32'h184; b_reg_wrt_i = 1; b_reg_addr_i = 5; b_reg_data_i = 32'h1234;
    b_mem_wrt_i = 1; b_mem_addr_i = 32'h80; b_mem_data_i = 32'h55;
    step();
    idle_lanes();
    expect_head("x0", 32'h180, 16'd4);
    chk("x0_reg_wrt", 64'(trc_reg_wrt_o), 64'd0);
    chk("x0_reg_data", 64'(trc_reg_data_o), 64'd0);
    chk("x0_mem_addr", 64'(trc_mem_addr_o), 64'd0);
    chk("x0_mem_data", 64'(trc_mem_data_o), 64'd0);
    trc_ready_i = 1;
    step();
    expect_head("rw5", 32'h184, 16'd5);
    chk("rw5_reg_wrt", 64'(trc_reg_wrt_o), 64'd1);
    chk("rw5_reg_addr", 64'(trc_reg_addr_o), 64'd5);
    chk("rw5_reg_data", 64'(trc_reg_data_o), 64'h1234);
    chk("rw5_mem", 64'({trc_mem_wrt_o, trc_mem_addr_o, trc_mem_data_o}), {31'd0, 1'b1, 32'h80, 32'h55} >> 0);
    step();

    // Younger lane alone
    retire(0, 32'h0, 1, 32'h300, 0);
    expect_head("solo", 32'h300, 16'd6);
    step();

    // Stall hold
    trc_ready_i = 0;
    retire(1, 32'h200, 1, 32'h204, 0);
    hold_pc = trc_pc_o; hold_instr = trc_instr_o; hold_seq = trc_seq_o;
    expect_head("hold", 32'h200, 16'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pc", 64'(trc_pc_o), 64'h200);
      chk("hold_instr", 64'(trc_instr_o), 64'(32'h200 ^ 32'hA5A5_0000));
      chk("hold_seq", 64'(trc_seq_o), 64'd7);
      chk("hold_level", 64'(level_o), 64'd2);
    end
    trc_ready_i = 1;
    step();
    trc_ready_i = 0;
    expect_head("adv", 32'h204, 16'd8);
    chk("adv_level", 64'(level_o), 64'd1);

    // Clear drops a same-cycle push
    clr_i = 1; a_valid_i = 1; a_pc_i = 32'h250;
    step();
    clr_i = 0; idle_lanes();
    chk("clr_level", 64'(level_o), 64'd0);
    chk("clr_valid", 64'(trc_valid_o), 64'd0);

    // Fill, overflow, drain
    for (int k = 0; k < 4; k++) retire(1, 32'h400 + 32'(8 * k), 1, 32'h404 + 32'(8 * k), 0);
    chk("full_level", 64'(level_o), 64'd8);
    chk("full_ovf", 64'(overflow_o), 64'd0);
    retire(1, 32'h420, 1, 32'h424, 0);
    chk("ovf_level", 64'(level_o), 64'd8);
    chk("ovf_set", 64'(overflow_o), 64'd1);
    trc_ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      expect_head("drain", 32'h400 + 32'(4 * i), 16'(i));
      step();
    end
    chk("drain_empty", 64'(trc_valid_o), 64'd0);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    trc_ready_i = 0;
    retire(1, 32'h500, 0, 32'h0, 0);
    expect_head("gap", 32'h500, 16'd10);

    // Partial fit
    clr_i = 1;
    step();
    clr_i = 0;
    chk("clr_ovf", 64'(overflow_o), 64'd0);
    for (int k = 0; k < 3; k++) retire(1, 32'h600 + 32'(8 * k), 1, 32'h604 + 32'(8 * k), 0);
    retire(1, 32'h618, 0, 32'h0, 0);
    chk("pf_level7", 64'(level_o), 64'd7);
    retire(1, 32'h620, 1, 32'h61C, 1);
    chk("pf_level8", 64'(level_o), 64'd8);
    chk("pf_ovf", 64'(overflow_o), 64'd1);
    trc_ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      expect_head("pf_drain", 32'h600 + 32'(4 * i), 16'(i));
      step();
    end
    trc_ready_i = 0;
    retire(1, 32'h700, 0, 32'h0, 0);
    expect_head("pf_next", 32'h700, 16'd9);

    // Reset mid-stream
    retire(1, 32'h800, 1, 32'h804, 0);
    retire(1, 32'h808, 1, 32'h80C, 0);
    chk("mid_level", 64'(level_o), 64'd5);
    rstn_i = 0;
    #1;
    chk("mid_rst_level", 64'(level_o), 64'd0);
    chk("mid_rst_valid", 64'(trc_valid_o), 64'd0);
    chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
    chk("mid_rst_pc", 64'(trc_pc_o), 64'd0);
    @(negedge clk);
    rstn_i = 1;
    step();
    retire(1, 32'h900, 0, 32'h0, 0);
    expect_head("post_rst", 32'h900, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dual_retire_tracer.md
Name: dual_retire_tracer

Overview:
- Consumes the per-lane write-back retirement outputs of both datapath ways: PC, instruction, register write and memory write.
- Merges them into one program-ordered trace stream with a valid/ready handshake, buffered by a FIFO.
- Sits beside the two-way core and feeds the testbench logger / debug trace port.
- Lane order per cycle follows the W-stage order-change flag.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- SEQ_W, 16, width of the retirement sequence counter.

Ports:
- clk  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear: empties FIFO, zeroes seq and overflow
- a_valid_i  in  1  lane 1 (first way) retirement valid this cycle
- a_pc_i  in  32  lane 1 retired PC
- a_instr_i  in  32  lane 1 instruction
- a_reg_wrt_i  in  1  lane 1 register write enable
- a_reg_addr_i  in  5  lane 1 destination register
- a_reg_data_i  in  32  lane 1 write-back data
- a_mem_wrt_i  in  1  lane 1 store
- a_mem_addr_i  in  32  lane 1 store address
- a_mem_data_i  in  32  lane 1 store data
- b_valid_i, b_pc_i, b_instr_i, b_reg_wrt_i, b_reg_addr_i, b_reg_data_i, b_mem_wrt_i, b_mem_addr_i, b_mem_data_i  in  same widths  lane 2 (second way) equivalents
- order_change_w_i  in  1  1 = lane 2 is older than lane 1 this cycle
- trc_valid_o  out  1  trace entry available
- trc_ready_i  in  1  consumer accepts entry
- trc_pc_o, trc_instr_o, trc_reg_addr_o (5), trc_reg_data_o, trc_reg_wrt_o (1), trc_mem_wrt_o (1), trc_mem_addr_o, trc_mem_data_o  out  head-entry payload; 32-bit unless width given
- trc_seq_o  out  SEQ_W  sequence number of head entry
- level_o  out  $clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: one or more retirements dropped

Behaviour:
- Reset (rstn_i low, async): read pointer, write pointer, seq counter and overflow all 0. FIFO empty. All outputs 0.
- Priority: reset > clr_i > normal operation. clr_i in a cycle drops any same-cycle push and pop.
- Entry normalisation on push:
  - reg_wrt = valid & reg_wrt & (reg_addr != 0).
  - reg_data and reg_addr forced to 0 when the normalised reg_wrt is 0.
  - mem_addr and mem_data forced to 0 when mem_wrt is 0.
- Ordering: older = lane 2 if order_change_w_i, else lane 1. Pushes are older first. A valid younger lane with an invalid older lane pushes alone.
- Sequence numbering:
  - Each valid retirement consumes one seq value, older first, whether stored or dropped. Gaps in trc_seq_o therefore mark drops.
  - seq wraps modulo 2^SEQ_W.
- Free-space rule:
  - free = DEPTH - level, measured at the start of the cycle. A same-cycle pop is not credited.
  - Need 2, free ≥ 2: both pushed.
  - Need 2, free = 1: older pushed, younger dropped, overflow_o set.
  - Need 1 or 2, free = 0: all dropped, overflow_o set.
- overflow_o stays set until reset or clr_i.
- Pop: occurs when trc_valid_o & trc_ready_i at a clock edge. Read pointer advances by 1.
- trc_valid_o = (level != 0). Payload is the head entry and stays stable while valid & !ready.
- Latency: a retirement presented in cycle N appears at the head no earlier than after edge N. With an empty FIFO, trc_valid_o rises in cycle N+1.
- level update: level' = level + pushes − pop, always within 0..DEPTH. Pointers carry one extra wrap bit for full/empty.
- Simultaneous push and pop when full: pop proceeds; new pushes drop per the free-space rule.

Test Plan:
- Reset mid-stream: 5 entries queued, rstn_i pulsed low → level_o=0, trc_valid_o=0, overflow_o=0 immediately; next retirement gets seq 0.
- Order swap: a_pc=0x100, b_pc=0x104, order_change_w_i=0, both valid, ready=1 → trace order 0x100 (seq 0) then 0x104 (seq 1). Repeat with order_change_w_i=1, a_pc=0x10C, b_pc=0x108 → 0x108 (seq 2) then 0x10C (seq 3).
- x0 filter: a_reg_wrt=1, a_reg_addr=0, a_reg_data=0xDEAD → entry has trc_reg_wrt_o=0, trc_reg_data_o=0.
- Backpressure/overflow, DEPTH=8, ready=0: 4 cycles of dual retire → level=8. 5th dual retire → both dropped, overflow_o=1, seq jumps by 2. Ready=1 → 8 entries drain, seq 0..7.
- Partial fit: level=7, dual retire → older stored, younger dropped, level=8, overflow_o=1. Next accepted entry's seq is 2 greater than the stored one.
- Stall hold: ready=0 for 3 cycles with head pc=0x200 → all trc_* outputs unchanged. Ready=1 for 1 cycle → head advances, level decrements by 1.
